bit_scan_sequencer: RTL and testbench

Downstream consumer of the junior-bit screening stage. It accepts a request word and serially issues one grant per set bit, lowest index first. Each grant is the isolated junior bit of the still-pending word. Grants are issued as a one-hot word plus a binary index under a valid/ready handshake, so a multi-bit request mask becomes an ordered stream of single-bit service events.

---
 rtl/bit_scan_pkg.sv | 9 +
 rtl/onehot_to_index.sv | 22 ++
 rtl/screening_by_junior.sv | 20 ++
 rtl/bit_scan_sequencer.sv | 104 ++++++++++
 tb/tb_bit_scan_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bit_scan_pkg.sv
// rtl/bit_scan_pkg.sv - shared types for the bit scan sequencer
package bit_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_to_index.sv
// rtl/onehot_to_index.sv - OR-tree binary encoder for a one-hot word
module onehot_to_index #(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  onehot_i,
    output logic [INDEX_WIDTH-1:0] index_o
);

    // Index bit b is the OR of every one-hot position whose index has bit b set.
    always_comb begin
        index_o = '0;
        for (int b = 0; b < INDEX_WIDTH; b++) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
                if (((i >> b) & 1) == 1) begin
                    index_o[b] = index_o[b] | onehot_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/screening_by_junior.sv
// rtl/screening_by_junior.sv - isolates the lowest set bit of a word, chainable via carry
module screening_by_junior #(
    parameter int WIDTH = 8
) (
    input  logic             c_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             c_o
);

    // A carry-in means a junior bit was already claimed further down the chain.
    always_comb begin
        data_o = '0;
        if (!c_i) begin
            data_o = data_i & ~(data_i - WIDTH'(1));
        end
        c_o = c_i | (|data_i);
    end

endmodule

// File: rtl/bit_scan_sequencer.sv
// rtl/bit_scan_sequencer.sv - serialises a request mask into one grant per set bit, lowest first
module bit_scan_sequencer
    import bit_scan_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [WORD_WIDTH-1:0]  req_data_i,
    output logic                   grant_valid_o,
    input  logic                   grant_ready_i,
    output logic [WORD_WIDTH-1:0]  grant_onehot_o,
    output logic [INDEX_WIDTH-1:0] grant_index_o,
    output logic                   grant_last_o,
    output logic                   done_o,
    output logic                   busy_o,
    input  logic                   flush_i
);

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   pend_q, pend_d;
    logic                    done_q, done_d;
    logic [WORD_WIDTH-1:0]   junior_bit;
    logic                    unused_carry;
    logic                    req_fire;
    logic                    grant_fire;

    screening_by_junior #(
        .WIDTH (WORD_WIDTH)
    ) u_screen (
        .c_i    (1'b0),
        .data_i (pend_q),
        .data_o (junior_bit),
        .c_o    (unused_carry)
    );

    onehot_to_index #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_encode (
        .onehot_i (grant_onehot_o),
        .index_o  (grant_index_o)
    );

    // Pending is always zero outside SCAN, so gating by state only guards the encoding.
    assign busy_o         = (state_q == SCAN);
    assign grant_valid_o  = busy_o;
    assign grant_onehot_o = busy_o ? junior_bit : '0;
    assign grant_last_o   = busy_o && ((pend_q & ~junior_bit) == '0);
    assign req_ready_o    = rst_ni && (state_q == IDLE) && !flush_i;
    assign done_o         = done_q;
    assign req_fire       = req_valid_i && req_ready_o;
    assign grant_fire     = grant_valid_o && grant_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (req_data_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = req_data_i;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Flush discards any grant handshake landing in the same cycle.
                if (flush_i) begin
                    pend_d  = '0;
                    state_d = IDLE;
                end else if (grant_fire) begin
                    pend_d = pend_q & ~junior_bit;
                    if (grant_last_o) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// tb/tb_bit_scan_sequencer.sv - randomized and directed checks against a queue-based reference model
module tb_bit_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = '0;
    logic       grant_valid;
    logic       grant_ready = 1'b0;
    logic [7:0] grant_onehot;
    logic [2:0] grant_index;
    logic       grant_last;
    logic       done;
    logic       busy;
    logic       flush = 1'b0;

    int checks = 0;
    int errors = 0;

    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_pend[$];
    int grant_log[$];
    bit saw_done = 1'b0;
    bit saw_grant = 1'b0;

    always #5 clk = ~clk;

    bit_scan_sequencer #(.WORD_WIDTH(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .grant_valid_o  (grant_valid),
        .grant_ready_i  (grant_ready),
        .grant_onehot_o (grant_onehot),
        .grant_index_o  (grant_index),
        .grant_last_o   (grant_last),
        .done_o         (done),
        .busy_o         (busy),
        .flush_i        (flush)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_pend.delete();
    endtask

    task automatic compare_outputs();
        logic [7:0] exp_onehot;
        int         exp_index;
        exp_onehot = '0;
        exp_index  = 0;
        if (m_busy) begin
            exp_index  = m_pend[0];
            exp_onehot = 8'(1 << m_pend[0]);
        end
        check_value("req_ready", 32'(req_ready), 32'(!m_busy && !flush));
        check_value("grant_valid", 32'(grant_valid), 32'(m_busy));
        check_value("grant_onehot", 32'(grant_onehot), 32'(exp_onehot));
        check_value("grant_index", 32'(grant_index), 32'(exp_index));
        check_value("grant_last", 32'(grant_last), 32'(m_busy && m_pend.size() == 1));
        check_value("done", 32'(done), 32'(m_done));
        check_value("busy", 32'(busy), 32'(m_busy));
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model to the next edge.
    task automatic cycle(input logic rv, input logic [7:0] rd, input logic gr, input logic fl);
        bit next_done;
        @(negedge clk);
        req_valid   = rv;
        req_data    = rd;
        grant_ready = gr;
        flush       = fl;
        #1;
        compare_outputs();
        if (done) saw_done = 1'b1;
        if (grant_valid) saw_grant = 1'b1;
        next_done = 1'b0;
        if (!m_busy) begin
            if (rv && !fl) begin
                m_pend.delete();
                for (int i = 0; i < 8; i++) if (rd[i]) m_pend.push_back(i);
                if (m_pend.size() == 0) next_done = 1'b1;
                else m_busy = 1'b1;
            end
        end else if (fl) begin
            m_pend.delete();
            m_busy = 1'b0;
        end else if (gr) begin
            grant_log.push_back(int'(grant_index));
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) begin
                m_busy    = 1'b0;
                next_done = 1'b1;
            end
        end
        m_done = next_done;
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check_value({tag, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            check_value({tag, "_idx"}, 32'(grant_log[i]), 32'(exp[i]));
    endtask

    initial begin
        // Reset: everything low including req_ready while rst_n is held.
        #12;
        check_value("rst_req_ready", 32'(req_ready), 32'd0);
        check_value("rst_grant_valid", 32'(grant_valid), 32'd0);
        check_value("rst_onehot", 32'(grant_onehot), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_value("post_rst_ready", 32'(req_ready), 32'd1);

        // Four-bit word with continuous ready.
        grant_log.delete(); saw_done = 1'b0;
        cycle(1, 8'b1010_0110, 0, 0);
        repeat (4) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        check_log("a6", '{1, 2, 5, 7});
        check_value("a6_done_seen", 32'(saw_done), 32'd1);

        // Backpressure holds the first grant for three cycles.
        grant_log.delete();
        cycle(1, 8'h81, 0, 0);
        repeat (3) cycle(0, 8'h00, 0, 0);
        repeat (2) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        check_log("81", '{0, 7});

        // Zero word: done with no grant.
        saw_done = 1'b0; saw_grant = 1'b0;
        cycle(1, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        check_value("zero_done_seen", 32'(saw_done), 32'd1);
        check_value("zero_no_grant", 32'(saw_grant), 32'd0);

        // Flush coincides with the third handshake.
        grant_log.delete(); saw_done = 1'b0;
        cycle(1, 8'hFF, 0, 0);
        repeat (2) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        check_value("flush_no_done", 32'(saw_done), 32'd0);
        check_log("ff", '{0, 1});
        grant_log.delete();
        cycle(1, 8'h10, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        check_log("10", '{4});

        // Asynchronous reset in the middle of a grant.
        cycle(1, 8'h40, 0, 0);
        cycle(0, 8'h00, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("arst_valid", 32'(grant_valid), 32'd0);
        check_value("arst_onehot", 32'(grant_onehot), 32'd0);
        check_value("arst_busy", 32'(busy), 32'd0);
        check_value("arst_ready", 32'(req_ready), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        grant_log.delete(); saw_done = 1'b0;
        cycle(1, 8'h40, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        check_log("40", '{6});
        check_value("40_done_seen", 32'(saw_done), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] w;
            w = 8'($urandom);
            if ($urandom_range(0, 7) == 0) w = '0;
            cycle(1'($urandom_range(0, 1)), w, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
        end
        repeat (12) cycle(0, 8'h00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
